// File: rtl/aon_apb_pkg.sv
// Shared types and register map for the AON APB arbiter slice.
package aon_apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam logic [31:0] REG0 = 32'h0000_0000;
    localparam logic [31:0] REG1 = 32'h0000_0004;

endpackage

// File: rtl/aon_rr_arbiter.sv
// Round-robin grant generator: one-hot grant among req_i; pointer moves past the winner on advance.
module aon_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] winIdx;
    logic [PW:0]   idx;
    logic          found;

    // ptr_q names the requester with highest priority this cycle
    always_comb begin
        grant_o = '0;
        winIdx  = ptr_q;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                found  = 1'b1;
                winIdx = idx[PW-1:0];
            end
        end
        if (found) begin
            grant_o[winIdx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (winIdx == PW'(N - 1)) ? '0 : winIdx + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aon_apb_arbiter.sv
// Shares the AON APB register-file slave among NUM_REQ requesters, one SETUP/ACCESS
// transfer per round-robin grant, with a registered per-owner response and ACCESS timeout.
module aon_apb_arbiter
    import aon_apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [NUM_REQ-1:0]              rq_valid,
    input  logic [NUM_REQ-1:0]              rq_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   rq_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   rq_wdata,
    output logic [NUM_REQ-1:0]              rq_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    apb_state_e              state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]      owner_q, owner_d;
    logic [TW-1:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      rspValid_q, rspValid_d;
    logic [DATA_WIDTH-1:0]   rspRdata_q, rspRdata_d;
    logic                    rspErr_q, rspErr_d;

    logic [NUM_REQ-1:0]      grant;
    logic                    arbAdvance;
    logic                    timeoutHit;
    logic                    selWrite;
    logic [ADDR_WIDTH-1:0]   selAddr;
    logic [DATA_WIDTH-1:0]   selWdata;

    assign arbAdvance = PRESETn && (state_q == IDLE);

    aon_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .req_i     (rq_valid),
        .advance_i (arbAdvance),
        .grant_o   (grant)
    );

    always_comb begin
        selWrite = 1'b0;
        selAddr  = '0;
        selWdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selWrite = rq_write[i];
                selAddr  = rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                selWdata = rq_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // cnt_q counts earlier stalled ACCESS cycles, so the current one is the TIMEOUT_CYCLES-th at TIMEOUT_CYCLES-1
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rspValid_d = '0;
        rspRdata_d = '0;
        rspErr_d   = 1'b0;
        timeoutHit = (TIMEOUT_CYCLES != 0) && !PREADY && (cnt_q == TW'(TIMEOUT_CYCLES - 1));
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = SETUP;
                    write_d = selWrite;
                    addr_d  = selAddr;
                    wdata_d = selWdata;
                    owner_d = grant;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (PREADY || timeoutHit) begin
                    state_d    = IDLE;
                    rspValid_d = owner_q;
                    rspRdata_d = (PREADY && !write_q) ? PRDATA : '0;
                    rspErr_d   = PREADY ? PSLVERR : 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            rspValid_q <= '0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // rq_ready is gated by PRESETn so every output reads 0 while reset is held
    assign rq_ready  = (PRESETn && (state_q == IDLE)) ? grant : '0;
    assign PSEL      = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = PSEL & write_q;
    assign PADDR     = PSEL ? addr_q : '0;
    assign PWDATA    = PSEL ? wdata_q : '0;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_aon_apb_arbiter.sv
// Randomized scoreboard bench for aon_apb_arbiter: transaction-level reference model plus a
// behavioural APB slave with random wait states, errors and stalls long enough to time out.
module tb_aon_apb_arbiter;
    import aon_apb_pkg::*;

    localparam int NREQ = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int TO   = 16;

    logic                 PCLK    = 1'b0;
    logic                 PRESETn = 1'b1;
    logic [NREQ-1:0]      rq_valid, rq_write, rq_ready, rsp_valid;
    logic [NREQ*AW-1:0]   rq_addr;
    logic [NREQ*DW-1:0]   rq_wdata;
    logic [DW-1:0]        rsp_rdata, PWDATA;
    logic                 rsp_err, PSEL, PENABLE, PWRITE;
    logic [AW-1:0]        PADDR;
    logic [DW-1:0]        PRDATA  = '0;
    logic                 PREADY  = 1'b0;
    logic                 PSLVERR = 1'b0;

    typedef struct {
        int            owner;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } rsp_t;

    typedef struct {
        int   waitCyc;
        logic err;
    } plan_t;

    rsp_t  sbQ[$];
    plan_t planQ[$];
    rsp_t  e, got;
    plan_t p;

    int checks    = 0;
    int failures  = 0;
    int cycle     = 0;
    int busyUntil = 0;
    int lastGrant = NREQ - 1;
    int forceWait = -1;
    int accCnt    = 0;

    bit              curActive = 1'b0;
    int              curAcc, curEnd;
    logic            curWrite;
    logic [AW-1:0]   curAddr;
    logic [DW-1:0]   curWdata;
    logic [NREQ-1:0] acceptVec = '0;
    logic [NREQ-1:0] expReady;

    logic [DW-1:0]   refMem[8];
    logic [DW-1:0]   slaveMem[8];
    logic            reqWrite[NREQ];
    logic [AW-1:0]   reqAddr[NREQ];
    logic [DW-1:0]   reqData[NREQ];

    aon_apb_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .rq_valid  (rq_valid),
        .rq_write  (rq_write),
        .rq_addr   (rq_addr),
        .rq_wdata  (rq_wdata),
        .rq_ready  (rq_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) cycle <= 0;
        else          cycle <= cycle + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Priority after a grant to 'last' is last+1 .. NREQ-1, 0 .. last
    function automatic logic [NREQ-1:0] rrWinner(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return NREQ'(1) << ((last + k) % NREQ);
        end
        return '0;
    endfunction

    function automatic int pickWait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 10)  return 0;
        if (r < 14)  return 1;
        if (r < 16)  return 2;
        if (r == 16) return 3;
        if (r == 17) return TO - 1;
        return TO + 24;
    endfunction

    task automatic packReqs();
        for (int i = 0; i < NREQ; i++) begin
            rq_write[i]             = reqWrite[i];
            rq_addr[i*AW +: AW]     = reqAddr[i];
            rq_wdata[i*DW +: DW]    = reqData[i];
        end
    endtask

    task automatic newReq(input int i);
        reqWrite[i] = 1'($urandom_range(0, 1));
        reqAddr[i]  = AW'($urandom_range(0, 7)) << 2;
        reqData[i]  = $urandom;
    endtask

    task automatic applyStimulus(input bit allowNew, input int pct);
        @(posedge PCLK);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acceptVec[i]) rq_valid[i] = 1'b0;
            if (!rq_valid[i] && allowNew && ($urandom_range(0, 99) < pct)) begin
                newReq(i);
                rq_valid[i] = 1'b1;
            end
        end
        packReqs();
    endtask

    // Slave: PREADY rises after the planned number of stalled ACCESS cycles
    always begin
        @(posedge PCLK);
        #1;
        if (!PRESETn) begin
            accCnt  = 0;
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end else if (PSEL && PENABLE) begin
            accCnt++;
            if (planQ.size() > 0 && accCnt > planQ[0].waitCyc) begin
                PREADY  = 1'b1;
                PRDATA  = slaveMem[PADDR[4:2]];
                PSLVERR = planQ[0].err;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end else begin
            accCnt  = 0;
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && planQ.size() > 0) begin
            if (PREADY) begin
                if (PWRITE && !PSLVERR) slaveMem[PADDR[4:2]] = PWDATA;
                void'(planQ.pop_front());
            end else if (accCnt == TO) begin
                void'(planQ.pop_front());
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            acceptVec = '0;
        end else begin
            if (rsp_valid != '0) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rsp_unexpected: got rsp_valid=%b expected none (cycle %0d)", rsp_valid, cycle);
                end else begin
                    got = sbQ.pop_front();
                    checkOutput("rsp_valid", rsp_valid, NREQ'(1) << got.owner);
                    checkOutput("rsp_rdata", rsp_rdata, got.rdata);
                    checkOutput("rsp_err", rsp_err, got.err);
                    checkOutput("rsp_cycle", cycle, got.cyc);
                end
            end else if (sbQ.size() > 0 && sbQ[0].cyc <= cycle) begin
                checks++;
                failures++;
                $display("[TB] FAIL rsp_missing: got no rsp_valid expected owner %0d at cycle %0d", sbQ[0].owner, sbQ[0].cyc);
                void'(sbQ.pop_front());
            end

            if (curActive && cycle > curAcc && cycle < curEnd) begin
                checkOutput("psel", PSEL, 1'b1);
                checkOutput("penable", PENABLE, (cycle >= curAcc + 2));
                checkOutput("paddr", PADDR, curAddr);
                checkOutput("pwrite", PWRITE, curWrite);
                checkOutput("pwdata", PWDATA, curWdata);
            end else begin
                checkOutput("psel_idle", PSEL, 1'b0);
                checkOutput("penable_idle", PENABLE, 1'b0);
                checkOutput("paddr_idle", PADDR, '0);
            end

            expReady = (cycle >= busyUntil) ? rrWinner(rq_valid, lastGrant) : '0;
            checkOutput("rq_ready", rq_ready, expReady);
            acceptVec = rq_valid & rq_ready;

            if (expReady != '0) begin
                for (int i = 0; i < NREQ; i++) if (expReady[i]) e.owner = i;
                lastGrant = e.owner;
                p.waitCyc = (forceWait >= 0) ? forceWait : pickWait();
                p.err     = ($urandom_range(0, 5) == 0);
                planQ.push_back(p);
                curWrite  = rq_write[e.owner];
                curAddr   = rq_addr[e.owner*AW +: AW];
                curWdata  = rq_wdata[e.owner*DW +: DW];
                if (p.waitCyc >= TO) begin
                    e.cyc   = cycle + 2 + TO;
                    e.rdata = '0;
                    e.err   = 1'b1;
                end else begin
                    e.cyc   = cycle + 3 + p.waitCyc;
                    e.err   = p.err;
                    e.rdata = curWrite ? '0 : refMem[curAddr[4:2]];
                    if (curWrite && !p.err) refMem[curAddr[4:2]] = curWdata;
                end
                sbQ.push_back(e);
                busyUntil = e.cyc;
                curActive = 1'b1;
                curAcc    = cycle;
                curEnd    = e.cyc;
            end
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rq_valid != '0 || sbQ.size() > 0) && n < 600) begin
            applyStimulus(1'b0, 0);
            n++;
        end
        if (rq_valid != '0 || sbQ.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s: got %0d pending responses expected 0", name, sbQ.size());
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            refMem[i]   = '0;
            slaveMem[i] = '0;
        end
        for (int i = 0; i < NREQ; i++) newReq(i);
        packReqs();
        rq_valid = '1;
        #1 PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #2;
        checkOutput("reset_rq_ready", rq_ready, '0);
        checkOutput("reset_psel", PSEL, 1'b0);
        checkOutput("reset_penable", PENABLE, 1'b0);
        checkOutput("reset_paddr", PADDR, '0);
        checkOutput("reset_pwdata", PWDATA, '0);
        checkOutput("reset_rsp_valid", rsp_valid, '0);
        checkOutput("reset_rsp_rdata", rsp_rdata, '0);
        checkOutput("reset_rsp_err", rsp_err, 1'b0);
        @(posedge PCLK);
        #1 PRESETn = 1'b1;
        #1 checkOutput("first_grant", rq_ready, 2'b01);

        $display("[TB] fairness phase");
        repeat (300) applyStimulus(1'b1, 100);
        $display("[TB] random phase");
        repeat (1500) applyStimulus(1'b1, 35);
        drain("drain_random");

        $display("[TB] reset during ACCESS");
        forceWait = TO + 24;
        @(posedge PCLK);
        #1;
        reqWrite[1] = 1'b0;
        reqAddr[1]  = REG1;
        reqData[1]  = '0;
        rq_valid    = 2'b10;
        packReqs();
        n = 0;
        while (!(PSEL && PENABLE) && n < 10) begin
            @(posedge PCLK);
            #1;
            if (acceptVec[1]) rq_valid[1] = 1'b0;
            n++;
        end
        checkOutput("reach_access", PSEL && PENABLE, 1'b1);
        rq_valid = '0;
        repeat (3) @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        for (int i = 0; i < NREQ; i++) newReq(i);
        packReqs();
        rq_valid = '1;
        #1;
        checkOutput("rst_mid_psel", PSEL, 1'b0);
        checkOutput("rst_mid_penable", PENABLE, 1'b0);
        checkOutput("rst_mid_rq_ready", rq_ready, '0);
        checkOutput("rst_mid_rsp_valid", rsp_valid, '0);
        sbQ.delete();
        planQ.delete();
        curActive = 1'b0;
        busyUntil = 0;
        lastGrant = NREQ - 1;
        forceWait = -1;
        acceptVec = '0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        #1 checkOutput("post_reset_grant", rq_ready, 2'b01);
        repeat (100) applyStimulus(1'b1, 50);
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
